// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e : transmit FSM states
//   PAR_EVEN / PAR_ODD : encodings of the PAR_TYP input
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity generator for one UART payload word.
//   data_i    : payload word
//   par_typ_i : PAR_EVEN or PAR_ODD
//   parity_o  : bit that makes the total count of ones even or odd
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  always_comb begin
    parity_o = (par_typ_i == PAR_EVEN) ? ^data_i : ~^data_i;
  end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator. One bit per CLK cycle.
// A frame is a start bit, DATA_WIDTH data bits LSB first, an optional
// parity bit, then one or two stop bits. Frames can run back to back.
//   CLK        : bit-rate clock
//   RST        : synchronous, active-high reset
//   P_DATA     : payload, latched on accept
//   Data_Valid : payload valid; accepted when TX_READY is high
//   PAR_EN     : insert parity bit
//   PAR_TYP    : 0 even, 1 odd parity
//   STOP_2     : 0 one stop bit, 1 two stop bits
//   TX_OUT     : registered serial line, idles high
//   Busy       : registered, high from start bit through last stop bit
//   TX_READY   : combinational, idle or on the final stop bit
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP_2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  TX_READY
);

  localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  par_calc;
  logic                  last_stop;
  logic                  accept;

  // Parity is computed from the word as presented and latched with it,
  // which is equivalent to latching PAR_TYP and the data separately.
  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data_i   (P_DATA),
    .par_typ_i(PAR_TYP),
    .parity_o (par_calc)
  );

  assign last_stop = (state_q == STOP) && (!stop2_q || stop_cnt_q);
  assign TX_READY  = !busy_q || last_stop;
  assign accept    = Data_Valid && TX_READY;
  assign TX_OUT    = tx_q;
  assign Busy      = busy_q;

  // state_q names the bit currently on the line; tx_d is the value of
  // the bit that the next state will put on the line.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
        tx_d      = shift_q[0];
      end
      DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          stop_cnt_d = 1'b0;
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = par_bit_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = shift_q >> 1;
          tx_d      = shift_q[1];
        end
      end
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 1'b0;
        tx_d       = 1'b1;
      end
      STOP: begin
        tx_d = 1'b1;
        if (last_stop) begin
          state_d    = IDLE;
          stop_cnt_d = 1'b0;
          busy_d     = 1'b0;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Accept overrides the IDLE / final-stop outcome so the next start
    // bit follows the last stop bit with no idle gap.
    if (accept) begin
      state_d    = START;
      shift_d    = P_DATA;
      par_en_d   = PAR_EN;
      stop2_d    = STOP_2;
      par_bit_d  = par_calc;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      par_bit_q  <= par_bit_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule
